logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
Parametrised, pipelined, multi-function bitwise logic unit. It is the successor to the team's single 2-input gate blocks.
- Folds NIN operands of WIDTH bits through a selectable gate function (AND/OR/XOR/NAND/NOR/XNOR/PASS/NOT).
- Optional accumulate mode chains each result into the next.
- Valid/ready handshakes on both sides; sits between a stimulus/register source and any downstream consumer.

Parameters:
WIDTH, 8, bit width of each operand and of the result (1..32)
NIN, 2, number of operands folded per transaction (2..8)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  source presents a transaction
in_ready  output  1  block can accept a transaction this cycle
in_op  input  3  function select (encoding below)
in_acc  input  1  include accumulator as leading operand
in_data  input  NIN*WIDTH  operands; operand k = in_data[k*WIDTH +: WIDTH], operand 0 is the LSB slice
out_valid  output  1  result valid
out_ready  input  1  sink accepts result
out_data  output  WIDTH  result
out_zero  output  1  out_data == 0
out_ones  output  1  out_data == all ones

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high; ports are named clk and rst.
- Reset values: in_ready=1 one cycle after deassertion (0 while rst high); out_valid=0; out_data=0; out_zero=1; out_ones=0; accumulator=0; all stage valids=0.
- Handshake: a transfer occurs when valid&&ready are both high on a rising edge. out_valid, out_data, out_zero and out_ones stay stable while out_valid=1 and out_ready=0. in_ready has no combinational path from in_valid.
- Pipeline: two register stages.
  - S1 captures in_data, in_op and in_acc.
  - S2 computes and registers the result.
  - Latency: accept at edge N gives out_valid=1 after edge N+2 with no backpressure. Throughput is 1 per cycle.
- Stage advance: S2 loads when !s2_valid || out_ready. S1 loads when !s1_valid || S2 loads. in_ready = !s1_valid || S2 loads.
- in_op encoding (fold left over operands 0..NIN-1):
  - 000 AND; 001 OR; 010 XOR.
  - 011 NAND, 100 NOR, 101 XNOR: the corresponding AND/OR/XOR fold, then inverted once at the end (not per pair).
  - 110 PASS: result = operand 0.
  - 111 NOT: result = ~operand 0.
- Accumulate:
  - If the S1 acc flag is set, the accumulator is prepended as an extra operand before folding. For PASS/NOT it replaces operand 0.
  - The accumulator is updated to the result on every S2 load, regardless of the acc flag.
  - Back-to-back acc transactions use the result of the immediately preceding transaction (forwarded from S2, not stale).
- out_zero and out_ones are registered with out_data and refer to the same result.
- Simultaneous events: an S2 drain and an S1 refill in the same cycle are legal; no bubble is inserted.
- Reset mid-operation: all in-flight transactions are discarded and the accumulator is cleared; no partial output is produced.
- Width rules: all operations are bitwise on WIDTH bits; no carries.

Decomposition:
- Shared package logic_pkg:
  - op encoding constants OP_AND..OP_NOT (3 bits)
  - function fold_op(op, operand vector, count) for reuse by the testbench model
- Sub-module logic_fold_comb: purely combinational NIN(+1)-operand fold, instantiated in S2.

Test Plan:
- Reset then WIDTH=8,NIN=2, op=000, operands (0x0F,0x3C), out_ready=1 -> out_data=0x0C two cycles after accept; out_zero=0, out_ones=0.
- NIN=4, op=101 (XNOR), operands 0xFF,0x0F,0xF0,0x00 -> XOR fold=0x00, out_data=0xFF, out_ones=1.
- Accumulate chain: op=001 acc=0 with (0x01,0x00) -> 0x01; then op=001 acc=1 with (0x02,0x00) back-to-back -> 0x03; then op=000 acc=1 with (0x01,0xFF) -> 0x01.
- Backpressure: stream 4 transactions, hold out_ready=0 for 5 cycles -> in_ready drops after 2 accepts; out_data stays stable; all 4 results emerge in order once released with no loss or duplication.
- Reset mid-stream: assert rst with s1 and s2 both valid -> out_valid=0 immediately (asynchronously); accumulator=0; next acc=1 OR with (0x00,0x00) yields 0x00.
- Op sweep: for each op 000..111 with operands (0xA5,0x5A) -> AND=0x00, OR=0xFF, XOR=0xFF, NAND=0xFF, NOR=0x00, XNOR=0x00, PASS=0xA5, NOT=0x5A.

Source files
------------

// File: rtl/logic_pkg.sv
// Shared definitions for the pipelined logic unit: op encodings and the
// operand fold used both by the datapath and by reference models.
package logic_pkg;

  // Widest supported operand and the largest operand list (NIN max + accumulator)
  localparam int MAX_W   = 32;
  localparam int MAX_OPS = 9;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_PASS = 3'd6;
  localparam logic [2:0] OP_NOT  = 3'd7;

  typedef logic [MAX_OPS-1:0][MAX_W-1:0] opvec_t;

  // Left fold of ops[0..count-1]. Inverting ops invert once after the fold,
  // PASS/NOT only look at ops[0] (the loop leaves r untouched for them).
  function automatic logic [MAX_W-1:0] fold_op(input logic [2:0] op,
                                               input opvec_t     ops,
                                               input int         count);
    logic [MAX_W-1:0] r;
    r = ops[0];
    for (int i = 1; i < MAX_OPS; i++) begin
      if (i < count) begin
        case (op)
          OP_AND, OP_NAND: r = r & ops[i];
          OP_OR,  OP_NOR:  r = r | ops[i];
          OP_XOR, OP_XNOR: r = r ^ ops[i];
          default:         r = r;
        endcase
      end
    end
    if (op == OP_NAND || op == OP_NOR || op == OP_XNOR || op == OP_NOT)
      r = ~r;
    return r;
  endfunction

endpackage

// File: rtl/logic_fold_comb.sv
// Combinational operand fold: NIN operands, optionally led by the accumulator.
module logic_fold_comb
  import logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NIN   = 2
) (
  input  logic [2:0]           op,
  input  logic                 acc_en,
  input  logic [WIDTH-1:0]     acc,
  input  logic [NIN*WIDTH-1:0] data,
  output logic [WIDTH-1:0]     res
);

  opvec_t ops;

  // Build the operand list (accumulator becomes operand 0 when enabled) and fold
  always_comb begin
    ops = '0;
    if (acc_en) begin
      ops[0] = MAX_W'(acc);
      for (int k = 0; k < NIN; k++) ops[k+1] = MAX_W'(data[k*WIDTH +: WIDTH]);
    end else begin
      for (int k = 0; k < NIN; k++) ops[k] = MAX_W'(data[k*WIDTH +: WIDTH]);
    end
    res = WIDTH'(fold_op(op, ops, acc_en ? NIN + 1 : NIN));
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with optional accumulate chaining.
module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NIN   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic                 in_acc,
  input  logic [NIN*WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_zero,
  output logic                 out_ones
);

  typedef struct packed {
    logic [2:0]           op;
    logic                 acc;
    logic [NIN*WIDTH-1:0] data;
  } req_t;

  logic [2:1]       vld_pipe;   // [1]=S1 holds a request, [2]=S2 holds a result
  req_t             s1;
  logic [WIDTH-1:0] accum;
  logic [WIDTH-1:0] res;
  logic             rdy_en;
  logic             s1_ld, s2_ld, in_fire;

  // Each stage advances when it is empty or its consumer takes its contents
  assign s2_ld     = !vld_pipe[2] || out_ready;
  assign s1_ld     = !vld_pipe[1] || s2_ld;
  assign in_ready  = rdy_en && s1_ld;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = vld_pipe[2];

  // accum always holds the last result loaded into S2, so a back-to-back
  // accumulate in S1 sees its predecessor's result without extra forwarding
  logic_fold_comb #(.WIDTH(WIDTH), .NIN(NIN)) u_fold (
    .op     (s1.op),
    .acc_en (s1.acc),
    .acc    (accum),
    .data   (s1.data),
    .res    (res)
  );

  // Hold in_ready low through reset and for the first edge after it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  // S1 captures requests, S2 registers results, flags and the accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      out_data <= '0;
      out_zero <= 1'b1;
      out_ones <= 1'b0;
      accum    <= '0;
    end else begin
      if (s1_ld) begin
        vld_pipe[1] <= in_fire;
        if (in_fire) s1 <= '{op: in_op, acc: in_acc, data: in_data};
      end
      if (s2_ld) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_data <= res;
          out_zero <= (res == '0);
          out_ones <= (res == '1);
          accum    <= res;
        end
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: NIN=2 main instance with a scoreboard
// model, plus a NIN=4 instance for wider folds.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // NIN=2 instance
  logic        iv, ir, iacc, ov, ordy, oz, oo;
  logic [2:0]  iop;
  logic [15:0] idata;
  logic [7:0]  od;
  // NIN=4 instance
  logic        iv4, ir4, iacc4, ov4, ordy4, oz4, oo4;
  logic [2:0]  iop4;
  logic [31:0] idata4;
  logic [7:0]  od4;

  int checks = 0;
  int errors = 0;

  logic_unit_pipe #(.WIDTH(8), .NIN(2)) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_op(iop), .in_acc(iacc),
    .in_data(idata), .out_valid(ov), .out_ready(ordy), .out_data(od),
    .out_zero(oz), .out_ones(oo));

  logic_unit_pipe #(.WIDTH(8), .NIN(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_op(iop4), .in_acc(iacc4),
    .in_data(idata4), .out_valid(ov4), .out_ready(ordy4), .out_data(od4),
    .out_zero(oz4), .out_ones(oo4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: identity-seeded fold over a queue of operands
  function automatic logic [7:0] model(input logic [2:0] op, input logic use_acc,
                                       input logic [7:0] accv, input logic [7:0] opnds[$]);
    logic [7:0] q[$];
    logic [7:0] r;
    q = opnds;
    if (use_acc) q.push_front(accv);
    case (op)
      3'd6: return q[0];
      3'd7: return ~q[0];
      3'd0, 3'd3: begin r = 8'hFF; foreach (q[i]) r &= q[i]; end
      3'd1, 3'd4: begin r = 8'h00; foreach (q[i]) r |= q[i]; end
      default:    begin r = 8'h00; foreach (q[i]) r ^= q[i]; end
    endcase
    return (op >= 3'd3) ? ~r : r;
  endfunction

  // Scoreboard state for the NIN=2 instance
  logic [7:0] expq[$];
  logic [7:0] outlog[$];
  logic [7:0] mq[$];
  logic [7:0] macc, m_e;
  int         accepts;
  logic       hold_v;
  logic [9:0] hold;
  logic [9:0] log4[$];
  logic [7:0] sweep_exp[8] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hA5, 8'h5A};

  // Compare process: inputs/outputs are stable at the falling edge
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      macc   = 8'h00;
      hold_v = 1'b0;
    end else begin
      if (hold_v) chk("hold_stable", {ov, oz, oo, od}, {1'b1, hold});
      hold_v = ov && !ordy;
      hold   = {oz, oo, od};
      if (ov && ordy) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out actual=%0h required=none", od);
        end else begin
          m_e = expq.pop_front();
          chk("out_data", od, m_e);
          chk("out_zero", oz, m_e == 8'h00);
          chk("out_ones", oo, m_e == 8'hFF);
          outlog.push_back(od);
        end
      end
      if (iv && ir) begin
        mq.delete();
        mq.push_back(idata[7:0]);
        mq.push_back(idata[15:8]);
        m_e  = model(iop, iacc, macc, mq);
        macc = m_e;
        expq.push_back(m_e);
        accepts++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov4 && ordy4) log4.push_back({oz4, oo4, od4});
  end

  task automatic send(input logic [2:0] op, input logic acc, input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    iv = 1'b1; iop = op; iacc = acc; idata = {b, a};
    while (1) begin
      @(negedge clk);
      if (ir) break;
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout actual=stalled required=accept");
        break;
      end
    end
    @(posedge clk); #1;
    iv = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || ov) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required=0", expq.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pin_q[$];
    int n;
    iv = 0; iop = 0; iacc = 0; idata = 0; ordy = 1;
    iv4 = 0; iop4 = 0; iacc4 = 0; idata4 = 0; ordy4 = 1;
    accepts = 0; macc = 0; hold_v = 0; hold = 0;

    // Model pins
    pin_q = '{8'hFF, 8'h0F, 8'hF0, 8'h00};
    chk("model_pin_xnor", model(3'd5, 1'b0, 8'h00, pin_q), 8'hFF);
    pin_q = '{8'h01, 8'hFF};
    chk("model_pin_acc_and", model(3'd0, 1'b1, 8'h03, pin_q), 8'h01);

    // Reset state
    #12;
    chk("rst_in_ready", ir, 0);
    chk("rst_out_valid", ov, 0);
    chk("rst_out_data", od, 0);
    chk("rst_out_zero", oz, 1);
    chk("rst_out_ones", oo, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", ir, 1);

    // AND with latency: captured at the first edge, result after the second
    iv = 1'b1; iop = 3'd0; iacc = 1'b0; idata = {8'h3C, 8'h0F};
    @(posedge clk); #1 iv = 1'b0;
    chk("lat_early", ov, 0);
    @(posedge clk); #1;
    chk("lat_valid", ov, 1);
    chk("and_data", od, 8'h0C);
    chk("and_zero", oz, 0);
    chk("and_ones", oo, 0);
    drain();

    // Accumulate chain, back-to-back
    outlog.delete();
    send(3'd1, 1'b0, 8'h01, 8'h00);
    send(3'd1, 1'b1, 8'h02, 8'h00);
    send(3'd0, 1'b1, 8'h01, 8'hFF);
    drain();
    chk("acc_count", outlog.size(), 3);
    if (outlog.size() == 3) begin
      chk("acc0", outlog[0], 8'h01);
      chk("acc1", outlog[1], 8'h03);
      chk("acc2", outlog[2], 8'h01);
    end

    // Op sweep
    outlog.delete();
    for (int op = 0; op < 8; op++) send(3'(op), 1'b0, 8'hA5, 8'h5A);
    drain();
    chk("sweep_count", outlog.size(), 8);
    if (outlog.size() == 8)
      for (int k = 0; k < 8; k++) chk($sformatf("sweep_op%0d", k), outlog[k], sweep_exp[k]);

    // Backpressure
    outlog.delete();
    accepts = 0;
    ordy = 1'b0;
    fork
      begin
        send(3'd0, 1'b0, 8'hF0, 8'hFF);
        send(3'd1, 1'b0, 8'h11, 8'h22);
        send(3'd2, 1'b0, 8'h33, 8'h0F);
        send(3'd6, 1'b0, 8'h44, 8'h00);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("bp_accepts", accepts, 2);
        chk("bp_in_ready", ir, 0);
        chk("bp_out_valid", ov, 1);
        ordy = 1'b1;
      end
    join
    drain();
    chk("bp_count", outlog.size(), 4);
    if (outlog.size() == 4) begin
      chk("bp0", outlog[0], 8'hF0);
      chk("bp1", outlog[1], 8'h33);
      chk("bp2", outlog[2], 8'h3C);
      chk("bp3", outlog[3], 8'h44);
    end

    // Reset with both stages occupied
    outlog.delete();
    ordy = 1'b0;
    send(3'd1, 1'b0, 8'hAA, 8'h00);
    send(3'd1, 1'b0, 8'h55, 8'h00);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", ov, 0);
    chk("mid_rst_in_ready", ir, 0);
    chk("mid_rst_out_data", od, 0);
    chk("mid_rst_out_zero", oz, 1);
    @(posedge clk); #1 rst = 1'b0;
    ordy = 1'b1;
    @(posedge clk); #1;
    send(3'd1, 1'b1, 8'h00, 8'h00);
    drain();
    chk("post_rst_count", outlog.size(), 1);
    if (outlog.size() == 1) chk("post_rst_acc", outlog[0], 8'h00);

    // NIN=4: XNOR fold, then AND with accumulator prepended
    log4.delete();
    iv4 = 1'b1; iop4 = 3'd5; iacc4 = 1'b0; idata4 = {8'h00, 8'hF0, 8'h0F, 8'hFF};
    @(posedge clk); #1;
    iop4 = 3'd0; iacc4 = 1'b1; idata4 = {8'hFF, 8'hFF, 8'hFF, 8'h0F};
    @(posedge clk); #1 iv4 = 1'b0;
    n = 0;
    while (log4.size() < 2 && n < 20) begin @(posedge clk); #1; n++; end
    chk("nin4_count", log4.size(), 2);
    if (log4.size() == 2) begin
      chk("nin4_xnor", log4[0], {1'b0, 1'b1, 8'hFF});
      chk("nin4_acc_and", log4[1], {1'b0, 1'b0, 8'h0F});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
